nibble_serial_sub: RTL and testbench



---
 rtl/nibble_sub_pkg.sv | 20 ++
 rtl/nibble_serial_sub_if.sv | 30 +++
 rtl/nibble_serial_sub_cla4_slice.sv | 38 +++
 rtl/nibble_serial_sub.sv | 146 ++++++++++++++
 tb/tb_nibble_serial_sub.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_sub_pkg.sv
// nibble_sub_pkg -- shared definitions for the nibble-serial subtractor.
//   NIBBLE_W    : width of one arithmetic slice (bits processed per clock)
//   sub_state_t : controller states (IDLE -> RUN -> DONE -> IDLE)
//   nib_count() : number of slice iterations for a given operand width
package nibble_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // WIDTH is expected to be a non-zero multiple of NIBBLE_W.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_if.sv
// nibble_serial_sub_if -- operand/result handshake bundle of the subtractor.
//   start_valid/start_ready : operand handshake (a, b, borrow_in)
//   res_valid/res_ready     : result handshake (diff, borrow_out, zero, overflow)
//   master : the side that supplies operands and consumes results
//   slave  : the subtractor itself
interface nibble_serial_sub_if #(parameter int WIDTH = 16);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  logic             overflow;

  modport master (
    output start_valid, a, b, borrow_in, res_ready,
    input  start_ready, res_valid, diff, borrow_out, zero, overflow
  );

  modport slave (
    input  start_valid, a, b, borrow_in, res_ready,
    output start_ready, res_valid, diff, borrow_out, zero, overflow
  );

endinterface

// File: rtl/nibble_serial_sub_cla4_slice.sv
// cla4_slice -- combinational 4-bit carry-lookahead adder.
//   x, y : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out
// Every carry is written as a flat sum of generate/propagate products so no
// carry depends on another carry output.
module cla4_slice
  import nibble_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g_s;
  logic [NIBBLE_W-1:0] p_s;
  logic [NIBBLE_W:0]   c_s;

  // Generate/propagate terms, flat lookahead carries and the sum bits.
  always_comb begin
    g_s = x & y;
    p_s = x ^ y;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    s    = p_s ^ c_s[NIBBLE_W-1:0];
    cout = c_s[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub -- sequential WIDTH-bit subtractor, diff = a - b - borrow_in.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of nibble_serial_sub_if (operand and result handshakes)
// One nibble per clock goes through a single cla4_slice as a + ~b + carry; the
// carry register starts at ~borrow_in and a final carry of 0 means a borrow.
// Result is flagged valid NIB edges after accept and held until res_ready.
module nibble_serial_sub
  import nibble_sub_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_sub_if.slave  bus
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  sub_state_t          state_r;
  sub_state_t          state_nx_s;
  logic [IDX_W-1:0]    idx_r;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic                carry_r;
  logic [WIDTH-1:0]    diff_r;
  logic                borrow_r;
  logic                zero_r;
  logic                ovf_r;
  logic                start_ready_r;
  logic                res_valid_r;

  int                  nib_base_s;
  logic [NIBBLE_W-1:0] a_nib_s;
  logic [NIBBLE_W-1:0] b_inv_s;
  logic [NIBBLE_W-1:0] sum_s;
  logic                cout_s;
  logic [WIDTH-1:0]    diff_nx_s;

  // Select the current operand nibbles and merge the new sum into the result.
  always_comb begin
    nib_base_s = int'(idx_r) * NIBBLE_W;
    a_nib_s    = a_r[nib_base_s +: NIBBLE_W];
    b_inv_s    = ~b_r[nib_base_s +: NIBBLE_W];
    diff_nx_s  = diff_r;
    diff_nx_s[nib_base_s +: NIBBLE_W] = sum_s;
  end

  cla4_slice u_slice (
    .x    (a_nib_s),
    .y    (b_inv_s),
    .cin  (carry_r),
    .s    (sum_s),
    .cout (cout_s)
  );

  // Controller next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start_valid) state_nx_s = RUN;
        else                 state_nx_s = IDLE;
      end
      RUN: begin
        if (idx_r == IDX_LAST) state_nx_s = DONE;
        else                   state_nx_s = RUN;
      end
      DONE: begin
        if (bus.res_ready) state_nx_s = IDLE;
        else               state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Handshake outputs registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_ready_r <= 1'b1;
      res_valid_r   <= 1'b0;
    end else begin
      start_ready_r <= (state_nx_s == IDLE);
      res_valid_r   <= (state_nx_s == DONE);
    end
  end

  // Operand capture, nibble iteration and flag capture on the last nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= {IDX_W{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_valid) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= ~bus.borrow_in;
            idx_r   <= {IDX_W{1'b0}};
          end
        end
        RUN: begin
          diff_r  <= diff_nx_s;
          carry_r <= cout_s;
          if (idx_r == IDX_LAST) begin
            borrow_r <= ~cout_s;
            zero_r   <= (diff_nx_s == {WIDTH{1'b0}});
            // Same-sign operands cannot overflow a subtraction.
            ovf_r    <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                        (diff_nx_s[WIDTH-1] != a_r[WIDTH-1]);
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          // Results hold until hand-off and beyond, up to the next accept.
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.diff        = diff_r;
  assign bus.borrow_out  = borrow_r;
  assign bus.zero        = zero_r;
  assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub -- self-checking bench for nibble_serial_sub (WIDTH=16).
// Directed vector table, back-pressure, mid-operation reset and random
// operands checked against an integer-arithmetic reference.
module tb_nibble_serial_sub;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  nibble_serial_sub_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bo;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                output logic [15:0] d, output logic bo, output logic z,
                                output logic ov);
    int u;
    int sres;
    u    = int'({16'd0, a}) - int'({16'd0, b}) - int'({31'd0, bin});
    bo   = (u < 0);
    d    = u[15:0];
    z    = (d == 16'd0);
    sres = int'($signed(a)) - int'($signed(b)) - int'({31'd0, bin});
    ov   = (sres < -32768) || (sres > 32767);
  endfunction

  // Waits for start_ready, accepts operands, scrambles inputs, counts edges to res_valid.
  task automatic do_accept(input logic [15:0] a, input logic [15:0] b, input logic bin,
                           output int lat);
    int w;
    w = 0;
    while (!bus.start_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("start_ready_wait", {31'd0, bus.start_ready}, 32'd1);
    bus.start_valid = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.borrow_in   = bin;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.a           = 16'($urandom);
    bus.b           = 16'($urandom);
    bus.borrow_in   = 1'($urandom);
    check("start_ready_busy", {31'd0, bus.start_ready}, 32'd0);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.res_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int lat, input logic [15:0] d,
                              input logic bo, input logic z, input logic ov);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_diff"}, {16'd0, bus.diff}, {16'd0, d});
    check({tag, "_borrow"}, {31'd0, bus.borrow_out}, {31'd0, bo});
    check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
    check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, ov});
  endtask

  task automatic handoff(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus.res_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.start_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic [15:0] d;
    logic        bo, z, ov;
    logic [15:0] ra, rb;
    logic        rbin;

    vecs[0] = '{"t1",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"t2",  16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"t3a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"t3b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"t4a", 16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"t4b", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"t7",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};

    bus.start_valid = 1'b0;
    bus.a           = 16'h0000;
    bus.b           = 16'h0000;
    bus.borrow_in   = 1'b0;
    bus.res_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.start_ready}, 32'd1);
    check("rst_diff", {16'd0, bus.diff}, 32'd0);
    check("rst_flags", {29'd0, bus.borrow_out, bus.zero, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      do_accept(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check_result(vecs[i].name, lat, vecs[i].diff, vecs[i].bo, vecs[i].z, vecs[i].ov);
      handoff(vecs[i].name);
      check({vecs[i].name, "_hold_diff"}, {16'd0, bus.diff}, {16'd0, vecs[i].diff});
    end

    // Back-pressure with start_valid and fresh operands held on the bus.
    do_accept(16'h1234, 16'h0234, 1'b0, lat);
    check_result("bp", lat, 16'h1000, 1'b0, 1'b0, 1'b0);
    bus.start_valid = 1'b1;
    bus.a           = 16'hFFFF;
    bus.b           = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, bus.res_valid}, 32'd1);
      check("bp_ready", {31'd0, bus.start_ready}, 32'd0);
      check("bp_diff", {16'd0, bus.diff}, 32'h1000);
      check("bp_flags", {29'd0, bus.borrow_out, bus.zero, bus.overflow}, 32'd0);
    end
    bus.start_valid = 1'b0;
    handoff("bp");
    check("bp_hold_diff", {16'd0, bus.diff}, 32'h1000);

    // Reset pulsed in the second RUN cycle.
    bus.start_valid = 1'b1;
    bus.a           = 16'h9999;
    bus.b           = 16'h1111;
    bus.borrow_in   = 1'b0;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, bus.res_valid}, 32'd0);
    check("mrst_diff", {16'd0, bus.diff}, 32'd0);
    check("mrst_ready", {31'd0, bus.start_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_accept(16'hFFFF, 16'h0001, 1'b0, lat);
    check_result("mrst_post", lat, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    handoff("mrst_post");

    // Random operands against the reference, with random result back-pressure.
    for (int i = 0; i < 40; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rbin, d, bo, z, ov);
      do_accept(ra, rb, rbin, lat);
      check_result("rnd", lat, d, bo, z, ov);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        @(posedge clk); #1;
        check("rnd_hold_valid", {31'd0, bus.res_valid}, 32'd1);
      end
      handoff("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
